// File: rtl/spi_device_rx.sv
// SPI receiver: oversampled nCS/SCLK/SDI, MSB-first byte capture into a small valid/ready FIFO.
// Optional frame counter output enabled by defining SPI_DEVICE_RX_FRAMECNT_EN.
module spi_device_rx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       nCS_i,
    input  logic       SCLK_i,
    input  logic       SDI_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic       clr_i,
    output logic       busy_o,
    output logic       overflow_o,
`ifdef SPI_DEVICE_RX_FRAMECNT_EN
    output logic [7:0] frame_cnt_o,
`endif
    output logic       frame_err_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StShift, StAbort} state_e;

    logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, sdi_sync_q, fill_q;
    logic                   sclk_prev_q;
    logic                   ncs_s, sclk_s, sdi_s, sync_ok, sclk_rise;

    state_e      state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        armed_q, busy_q, overflow_q, frame_err_q, pushed_any_q;
    logic [7:0]  frame_cnt_q;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        empty, full, pop, byte_done, push_ok;

    always_comb begin
        ncs_s     = ncs_sync_q[SYNC_STAGES-1];
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        sdi_s     = sdi_sync_q[SYNC_STAGES-1];
        sync_ok   = fill_q[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_prev_q;
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop       = ~empty & rx_ready_i;
        byte_done = (state_q == StShift) && !ncs_s && sclk_rise && (bit_cnt_q == 3'd7);
        push_ok   = byte_done && (!full || pop);
    end

    // fill_q marks when the chains hold real pin samples rather than reset values
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ncs_sync_q  <= '1;
            sclk_sync_q <= '1;
            sdi_sync_q  <= '1;
            fill_q      <= '0;
            sclk_prev_q <= 1'b1;
        end else begin
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], nCS_i};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_i};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], SDI_i};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {shift_q[6:0], sdi_s};
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            pushed_any_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
        end else begin
            if (clr_i) begin
                overflow_q  <= 1'b0;
                frame_err_q <= 1'b0;
            end
            // Re-arm only after a real nCS high, so a frame caught mid-way by reset is skipped
            if (sync_ok && ncs_s) armed_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (armed_q && sync_ok && !ncs_s) begin
                        state_q      <= StShift;
                        busy_q       <= 1'b1;
                        bit_cnt_q    <= 3'd0;
                        shift_q      <= 8'h00;
                        pushed_any_q <= 1'b0;
                    end
                end
                StShift: begin
                    if (ncs_s) begin
                        busy_q <= 1'b0;
                        if (bit_cnt_q == 3'd0) begin
                            state_q <= StIdle;
                            if (pushed_any_q) frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            state_q <= StAbort;
                        end
                    end else if (sclk_rise) begin
                        shift_q   <= {shift_q[6:0], sdi_s};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            pushed_any_q <= 1'b1;
                            if (!push_ok) overflow_q <= 1'b1;
                        end
                    end
                end
                StAbort: begin
                    frame_err_q <= 1'b1;
                    bit_cnt_q   <= 3'd0;
                    shift_q     <= 8'h00;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid_o  = ~empty;
    assign busy_o      = busy_q;
    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
`ifdef SPI_DEVICE_RX_FRAMECNT_EN
    assign frame_cnt_o = frame_cnt_q;
`else
    logic unused_frame_cnt;
    assign unused_frame_cnt = ^frame_cnt_q;
`endif
endmodule

// File: tb/tb_spi_device_rx.sv
// Bench for spi_device_rx: table of frames, hand-written corner sequences, random frames vs a queue model.
module tb_spi_device_rx;
    localparam int unsigned Depth = 4;

    logic       clk, rst, ncs, sclk, sdi, ready, clr;
    logic [7:0] rx_data;
    logic       rx_valid, busy, ovf, ferr;
`ifdef SPI_DEVICE_RX_FRAMECNT_EN
    logic [7:0] fcnt;
`endif

    spi_device_rx #(.FIFO_DEPTH(Depth), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .nCS_i(ncs), .SCLK_i(sclk), .SDI_i(sdi),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(ready), .clr_i(clr),
        .busy_o(busy), .overflow_o(ovf),
`ifdef SPI_DEVICE_RX_FRAMECNT_EN
        .frame_cnt_o(fcnt),
`endif
        .frame_err_o(ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural reference: FIFO contents as a queue, sticky flags, clean-frame count
    logic [7:0] exp_q[$];
    bit         m_ovf, m_ferr;
    int         m_fcnt;

    typedef struct {
        int          nbytes;
        logic [47:0] data;
        int          abort_bits;
        bit          exp_ovf;
        bit          exp_ferr;
    } vec_t;
    vec_t vecs[5];

    bit         mon_en;
    int         mon_cnt;
    logic [7:0] mon_data;
    always @(negedge clk) begin
        if (mon_en && rx_valid) begin
            mon_cnt  <= mon_cnt + 1;
            mon_data <= rx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            sdi  = b[7-i];
            wait_neg(5);
            sclk = 1'b1;
            wait_neg(5);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < Depth) exp_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] d, input int n, input int abort_bits);
        logic [7:0] b;
        ncs = 1'b0;
        wait_neg(5);
        for (int i = 0; i < n; i++) begin
            b = d[47-8*i -: 8];
            spi_bits(b, 8);
            model_push(b);
        end
        if (abort_bits > 0) begin
            b = d[47-8*n -: 8];
            spi_bits(b, abort_bits);
            m_ferr = 1'b1;
        end
        ncs = 1'b1;
        wait_neg(10);
        if (abort_bits == 0 && n > 0) m_fcnt = (m_fcnt + 1) % 256;
    endtask

    task automatic drain(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_valid"}, {31'd0, rx_valid}, 32'd1);
            chk({name, "_data"}, {24'd0, rx_data}, {24'd0, e});
            ready = 1'b1;
            wait_neg(1);
            ready = 1'b0;
        end
        chk({name, "_empty"}, {31'd0, rx_valid}, 32'd0);
    endtask

    task automatic clear_flags(input string name);
        clr = 1'b1;
        wait_neg(1);
        clr = 1'b0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        chk({name, "_clr_ovf"}, {31'd0, ovf}, 32'd0);
        chk({name, "_clr_ferr"}, {31'd0, ferr}, 32'd0);
    endtask

    initial begin
        logic [7:0] b55;
        rst = 1'b1; ncs = 1'b1; sclk = 1'b1; sdi = 1'b1; ready = 1'b0; clr = 1'b0;
        mon_en = 1'b0; m_ovf = 0; m_ferr = 0; m_fcnt = 0;
        vecs[0] = '{1, 48'hA5_0000000000, 0, 1'b0, 1'b0};
        vecs[1] = '{3, 48'h3C_FF_00_000000, 0, 1'b0, 1'b0};
        vecs[2] = '{5, 48'h01_02_03_04_05_00, 0, 1'b1, 1'b0};
        vecs[3] = '{0, 48'hF0_0000000000, 5, 1'b0, 1'b1};
        vecs[4] = '{1, 48'h81_0000000000, 0, 1'b0, 1'b0};

        wait_neg(3);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        rst = 1'b0;
        wait_neg(5);

        // Single byte with consumer always ready: valid for exactly one cycle
        ready = 1'b1; mon_en = 1'b1; mon_cnt = 0;
        ncs = 1'b0;
        wait_neg(5);
        chk("single_busy_hi", {31'd0, busy}, 32'd1);
        spi_bits(8'hA5, 8);
        ncs = 1'b1;
        wait_neg(10);
        m_fcnt = m_fcnt + 1;
        mon_en = 1'b0; ready = 1'b0;
        chk("single_pulse_len", mon_cnt, 32'd1);
        chk("single_data", {24'd0, mon_data}, 32'hA5);
        chk("single_busy_lo", {31'd0, busy}, 32'd0);
        chk("single_ovf", {31'd0, ovf}, 32'd0);
        chk("single_ferr", {31'd0, ferr}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].nbytes, vecs[v].abort_bits);
            chk($sformatf("vec%0d_ovf", v), {31'd0, ovf}, {31'd0, vecs[v].exp_ovf});
            chk($sformatf("vec%0d_ferr", v), {31'd0, ferr}, {31'd0, vecs[v].exp_ferr});
            drain($sformatf("vec%0d", v));
            clear_flags($sformatf("vec%0d", v));
        end

        // Full FIFO, pop coincides with the push of 0x55: no overflow
        send_frame(48'h11_12_13_14_0000, 4, 0);
        b55 = 8'h55;
        ncs = 1'b0;
        wait_neg(5);
        spi_bits(b55, 7);
        sclk = 1'b0; sdi = b55[0];
        wait_neg(5);
        sclk = 1'b1;
        wait_neg(2);
        ready = 1'b1;
        wait_neg(1);
        ready = 1'b0;
        wait_neg(2);
        ncs = 1'b1;
        wait_neg(10);
        void'(exp_q.pop_front());
        exp_q.push_back(b55);
        m_fcnt = m_fcnt + 1;
        chk("fullpop_ovf", {31'd0, ovf}, 32'd0);
        drain("fullpop");

        // Random frames, some long enough to overflow
        for (int r = 0; r < 8; r++) begin
            int n;
            logic [47:0] d;
            n = $urandom_range(1, 6);
            d = {$urandom, $urandom};
            send_frame(d, n, 0);
            chk($sformatf("rnd%0d_ovf", r), {31'd0, ovf}, {31'd0, m_ovf});
            chk($sformatf("rnd%0d_ferr", r), {31'd0, ferr}, {31'd0, m_ferr});
            drain($sformatf("rnd%0d", r));
            clear_flags($sformatf("rnd%0d", r));
        end

        // Async reset mid-frame with a byte pending in the FIFO
        send_frame(48'h11_0000000000, 1, 0);
        ncs = 1'b0;
        wait_neg(5);
        spi_bits(8'h7E, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, rx_valid}, 32'd0);
        chk("arst_data", {24'd0, rx_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete(); m_ovf = 0; m_ferr = 0; m_fcnt = 0;
        wait_neg(3);
        rst = 1'b0;
        spi_bits(8'hE0, 5);
        chk("arst_ignored_busy", {31'd0, busy}, 32'd0);
        chk("arst_ignored_valid", {31'd0, rx_valid}, 32'd0);
        ncs = 1'b1;
        wait_neg(10);
        send_frame(48'h7E_0000000000, 1, 0);
        chk("arst_ferr", {31'd0, ferr}, 32'd0);
        drain("arst");
`ifdef SPI_DEVICE_RX_FRAMECNT_EN
        chk("arst_fcnt", {24'd0, fcnt}, m_fcnt);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
